// File: rtl/wb_exc_ctrl.sv
// wb_exc_ctrl: writeback exception/ERET commit, pipeline flush, response drain and redirect
// Ports: clk/resetn (async, active low); ws_* WB instruction info and exception flags;
// has_int/c0_epc from CP0; mem_req_fire/mem_resp_fire track outstanding data requests;
// wb_ex/wb_excode/wb_bd/wb_pc/wb_badvaddr/eret_flush commit to CP0; pipe_flush kills
// older stages; resp_discard drops stale responses; redirect_valid/redirect_pc/redirect_ready
// hand the new fetch PC to the front end.
module wb_exc_ctrl #(
  parameter logic [31:0] EX_VECTOR = 32'hBFC00380,
  parameter int          OUTS_W    = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ws_valid,
  input  logic [31:0] ws_pc,
  input  logic        ws_bd,
  input  logic        ws_ex_adel_if,
  input  logic        ws_ex_ri,
  input  logic        ws_ex_ov,
  input  logic        ws_ex_sys,
  input  logic        ws_ex_bp,
  input  logic        ws_ex_adel_ld,
  input  logic        ws_ex_ades,
  input  logic [31:0] ws_data_addr,
  input  logic        ws_eret,
  input  logic        has_int,
  input  logic [31:0] c0_epc,
  input  logic        mem_req_fire,
  input  logic        mem_resp_fire,
  input  logic        redirect_ready,
  output logic        wb_ex,
  output logic [4:0]  wb_excode,
  output logic        wb_bd,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_badvaddr,
  output logic        eret_flush,
  output logic        pipe_flush,
  output logic        resp_discard,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);
  typedef enum logic [1:0] {IDLE, DRAIN, REDIR} state_t;
  state_t state, state_nxt;
  logic [OUTS_W-1:0] cnt, cnt_nxt;
  logic [31:0] target;
  logic any_ex, trig, data_ex;
  logic [4:0] code;
  always_comb begin
    cnt_nxt = cnt;
    if (mem_req_fire && !mem_resp_fire && cnt != '1) cnt_nxt = cnt + 1'b1;
    else if (!mem_req_fire && mem_resp_fire && cnt != '0) cnt_nxt = cnt - 1'b1;
  end
  assign any_ex = has_int | ws_ex_adel_if | ws_ex_ri | ws_ex_ov | ws_ex_sys | ws_ex_bp |
                  ws_ex_adel_ld | ws_ex_ades;
  // gated by resetn so every output is 0 while reset is held
  assign trig = resetn & (state == IDLE) & ws_valid & (any_ex | ws_eret);
  assign code = has_int       ? 5'h00 :
                ws_ex_adel_if ? 5'h04 :
                ws_ex_ri      ? 5'h0a :
                ws_ex_ov      ? 5'h0c :
                ws_ex_sys     ? 5'h08 :
                ws_ex_bp      ? 5'h09 :
                ws_ex_adel_ld ? 5'h04 :
                ws_ex_ades    ? 5'h05 : 5'h00;
  // data address faults win only when nothing of higher priority is present
  assign data_ex = ~has_int & ~ws_ex_adel_if & ~ws_ex_ri & ~ws_ex_ov & ~ws_ex_sys & ~ws_ex_bp &
                   (ws_ex_adel_ld | ws_ex_ades);
  assign wb_ex = trig & any_ex;
  assign wb_excode = wb_ex ? code : 5'h00;
  assign wb_bd = wb_ex & ws_bd;
  assign wb_pc = wb_ex ? ws_pc : 32'h0;
  assign wb_badvaddr = (wb_ex && !has_int && ws_ex_adel_if) ? ws_pc :
                       (wb_ex && data_ex) ? ws_data_addr : 32'h0;
  assign eret_flush = trig & ~any_ex;
  assign pipe_flush = trig | (state != IDLE);
  assign resp_discard = (state == DRAIN) & mem_resp_fire;
  assign redirect_valid = state == REDIR;
  assign redirect_pc = redirect_valid ? target : 32'h0;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = trig ? ((cnt_nxt != '0) ? DRAIN : REDIR) : IDLE;
      DRAIN:   state_nxt = (cnt_nxt == '0) ? REDIR : DRAIN;
      default: state_nxt = redirect_ready ? IDLE : REDIR;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      cnt    <= '0;
      target <= 32'h0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (trig) target <= any_ex ? EX_VECTOR : c0_epc;
    end
  end
endmodule

// File: tb/tb_wb_exc_ctrl.sv
// tb_wb_exc_ctrl: vector table, hand sequences and random run against a behavioural model
module tb_wb_exc_ctrl;
  localparam logic [31:0] EXV = 32'hBFC00380;
  logic clk = 1'b0, resetn = 1'b0;
  logic ws_valid, ws_bd, ws_ex_adel_if, ws_ex_ri, ws_ex_ov, ws_ex_sys, ws_ex_bp;
  logic ws_ex_adel_ld, ws_ex_ades, ws_eret, has_int, mem_req_fire, mem_resp_fire, redirect_ready;
  logic [31:0] ws_pc, ws_data_addr, c0_epc;
  logic wb_ex, wb_bd, eret_flush, pipe_flush, resp_discard, redirect_valid;
  logic [4:0] wb_excode;
  logic [31:0] wb_pc, wb_badvaddr, redirect_pc;
  logic [106:0] got, exp_v;
  int n_cmp = 0, n_bad = 0;
  int m_mode = 0, m_cnt = 0;
  logic [31:0] m_tgt = 32'h0;
  wb_exc_ctrl dut (
    .clk(clk), .resetn(resetn), .ws_valid(ws_valid), .ws_pc(ws_pc), .ws_bd(ws_bd),
    .ws_ex_adel_if(ws_ex_adel_if), .ws_ex_ri(ws_ex_ri), .ws_ex_ov(ws_ex_ov),
    .ws_ex_sys(ws_ex_sys), .ws_ex_bp(ws_ex_bp), .ws_ex_adel_ld(ws_ex_adel_ld),
    .ws_ex_ades(ws_ex_ades), .ws_data_addr(ws_data_addr), .ws_eret(ws_eret),
    .has_int(has_int), .c0_epc(c0_epc), .mem_req_fire(mem_req_fire),
    .mem_resp_fire(mem_resp_fire), .redirect_ready(redirect_ready), .wb_ex(wb_ex),
    .wb_excode(wb_excode), .wb_bd(wb_bd), .wb_pc(wb_pc), .wb_badvaddr(wb_badvaddr),
    .eret_flush(eret_flush), .pipe_flush(pipe_flush), .resp_discard(resp_discard),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );
  always #5 clk = ~clk;
  assign got = {wb_ex, wb_excode, wb_bd, wb_pc, wb_badvaddr, eret_flush, pipe_flush,
                resp_discard, redirect_valid, redirect_pc};
  typedef struct {
    string nm;
    logic valid; logic [31:0] pc; logic bd; logic [6:0] ex; logic [31:0] daddr;
    logic eret; logic intr; logic [31:0] epc;
    logic e_ex; logic [4:0] e_code; logic [31:0] e_bva; logic e_eret; logic [31:0] e_tgt;
  } vec_t;
  vec_t vt[12];
  task automatic chk(input string nm, input logic [31:0] g, input logic [31:0] e);
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, g, e);
    end
  endtask
  task automatic clear_inputs();
    ws_valid = 0; ws_pc = 0; ws_bd = 0; ws_ex_adel_if = 0; ws_ex_ri = 0; ws_ex_ov = 0;
    ws_ex_sys = 0; ws_ex_bp = 0; ws_ex_adel_ld = 0; ws_ex_ades = 0; ws_data_addr = 0;
    ws_eret = 0; has_int = 0; c0_epc = 0; mem_req_fire = 0; mem_resp_fire = 0;
    redirect_ready = 0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    resetn = 0;
    clear_inputs();
    #1;
    chk("reset_outputs", {25'h0, got[106:100]} | got[99:68] | got[67:36] | {28'h0, got[35:32]} | got[31:0], 32'h0);
    repeat (2) @(negedge clk);
    resetn = 1;
    m_mode = 0; m_cnt = 0; m_tgt = 0;
  endtask
  // Behavioural reference: outputs for the current inputs and model state
  function automatic logic [106:0] model_out();
    logic fl[8];
    logic [4:0] codes[8];
    logic any, trig, ex, found;
    logic [4:0] c;
    logic [31:0] bva;
    fl = '{has_int, ws_ex_adel_if, ws_ex_ri, ws_ex_ov, ws_ex_sys, ws_ex_bp, ws_ex_adel_ld, ws_ex_ades};
    codes = '{5'h00, 5'h04, 5'h0a, 5'h0c, 5'h08, 5'h09, 5'h04, 5'h05};
    any = 0; found = 0; c = 0; bva = 0;
    for (int i = 0; i < 8; i++) any |= fl[i];
    trig = (m_mode == 0) && ws_valid && (any || ws_eret);
    ex = trig && any;
    for (int i = 0; i < 8; i++)
      if (fl[i] && !found) begin
        found = 1;
        c = codes[i];
        if (i == 1) bva = ws_pc;
        if (i >= 6) bva = ws_data_addr;
      end
    return {ex, ex ? c : 5'h0, ex & ws_bd, ex ? ws_pc : 32'h0, ex ? bva : 32'h0,
            trig && !any, trig || m_mode != 0, m_mode == 1 && mem_resp_fire,
            m_mode == 2, m_mode == 2 ? m_tgt : 32'h0};
  endfunction
  task automatic model_step();
    logic any;
    int c;
    any = has_int | ws_ex_adel_if | ws_ex_ri | ws_ex_ov | ws_ex_sys | ws_ex_bp | ws_ex_adel_ld | ws_ex_ades;
    c = m_cnt + int'(mem_req_fire) - int'(mem_resp_fire);
    c = c < 0 ? 0 : (c > 7 ? 7 : c);
    if (m_mode == 0 && ws_valid && (any || ws_eret)) begin
      m_tgt = any ? EXV : c0_epc;
      m_mode = c != 0 ? 1 : 2;
    end else if (m_mode == 1 && c == 0) m_mode = 2;
    else if (m_mode == 2 && redirect_ready) m_mode = 0;
    m_cnt = c;
  endtask
  task automatic apply_vec(input vec_t v);
    logic t;
    t = v.e_ex | v.e_eret;
    @(negedge clk);
    ws_valid = v.valid; ws_pc = v.pc; ws_bd = v.bd; ws_data_addr = v.daddr;
    {ws_ex_adel_if, ws_ex_ri, ws_ex_ov, ws_ex_sys, ws_ex_bp, ws_ex_adel_ld, ws_ex_ades} = v.ex;
    ws_eret = v.eret; has_int = v.intr; c0_epc = v.epc;
    #1;
    chk({v.nm, ".wb_ex"}, {31'h0, wb_ex}, {31'h0, v.e_ex});
    chk({v.nm, ".excode"}, {27'h0, wb_excode}, {27'h0, v.e_code});
    chk({v.nm, ".bd"}, {31'h0, wb_bd}, {31'h0, v.e_ex & v.bd});
    chk({v.nm, ".pc"}, wb_pc, v.e_ex ? v.pc : 32'h0);
    chk({v.nm, ".badvaddr"}, wb_badvaddr, v.e_bva);
    chk({v.nm, ".eret_flush"}, {31'h0, eret_flush}, {31'h0, v.e_eret});
    chk({v.nm, ".pipe_flush"}, {31'h0, pipe_flush}, {31'h0, t});
    @(negedge clk);
    clear_inputs();
    c0_epc = 32'h5555AAAA;
    redirect_ready = 1;
    #1;
    chk({v.nm, ".redirect_valid"}, {31'h0, redirect_valid}, {31'h0, t});
    chk({v.nm, ".redirect_pc"}, redirect_pc, t ? v.e_tgt : 32'h0);
    @(negedge clk);
    redirect_ready = 0;
  endtask
  initial begin
    clear_inputs();
    vt[0]  = '{"ov", 1, 32'hBFC00100, 1, 7'b0010000, 0, 0, 0, 0, 1, 5'h0c, 0, 0, EXV};
    vt[1]  = '{"ri_sys", 1, 32'h00400010, 0, 7'b0101000, 0, 0, 0, 0, 1, 5'h0a, 0, 0, EXV};
    vt[2]  = '{"int_adelif", 1, 32'h00001234, 0, 7'b1000000, 0, 0, 1, 0, 1, 5'h00, 0, 0, EXV};
    vt[3]  = '{"ades", 1, 32'h00400020, 0, 7'b0000001, 32'h80000003, 0, 0, 0, 1, 5'h05, 32'h80000003, 0, EXV};
    vt[4]  = '{"adel_if", 1, 32'hBFC00123, 1, 7'b1000000, 0, 0, 0, 0, 1, 5'h04, 32'hBFC00123, 0, EXV};
    vt[5]  = '{"bp_adelld", 1, 32'h00400030, 0, 7'b0000110, 32'h11, 0, 0, 0, 1, 5'h09, 0, 0, EXV};
    vt[6]  = '{"adel_ld", 1, 32'h00400040, 0, 7'b0000010, 32'h80001001, 0, 0, 0, 1, 5'h04, 32'h80001001, 0, EXV};
    vt[7]  = '{"eret", 1, 32'h00400050, 0, 7'b0, 0, 1, 0, 32'hBFC00200, 0, 5'h00, 0, 1, 32'hBFC00200};
    vt[8]  = '{"eret_int", 1, 32'h00400060, 0, 7'b0, 0, 1, 1, 32'hBFC00200, 1, 5'h00, 0, 0, EXV};
    vt[9]  = '{"invalid_ov", 0, 32'h00400070, 0, 7'b0010000, 0, 0, 0, 0, 0, 5'h00, 0, 0, 0};
    vt[10] = '{"no_flag", 1, 32'h00400080, 1, 7'b0, 0, 0, 0, 0, 0, 5'h00, 0, 0, 0};
    vt[11] = '{"ov_ades", 1, 32'h00400090, 0, 7'b0010001, 32'h3, 0, 0, 0, 1, 5'h0c, 0, 0, EXV};
    do_reset();
    for (int i = 0; i < 12; i++) apply_vec(vt[i]);
    // two requests outstanding, exception, responses three cycles apart
    do_reset();
    @(negedge clk); mem_req_fire = 1;
    @(negedge clk); mem_req_fire = 1;
    @(negedge clk); mem_req_fire = 0; ws_valid = 1; ws_ex_ov = 1;
    #1; chk("drain.trig_ex", {31'h0, wb_ex}, 1);
    @(negedge clk); clear_inputs();
    #1; chk("drain.flush", {30'h0, pipe_flush, redirect_valid}, 32'h2);
    repeat (2) @(negedge clk);
    @(negedge clk); mem_resp_fire = 1;
    #1; chk("drain.discard1", {30'h0, resp_discard, redirect_valid}, 32'h2);
    @(negedge clk); mem_resp_fire = 0;
    #1; chk("drain.gap", {30'h0, resp_discard, redirect_valid}, 32'h0);
    repeat (2) @(negedge clk);
    @(negedge clk); mem_resp_fire = 1;
    #1; chk("drain.discard2", {30'h0, resp_discard, redirect_valid}, 32'h2);
    @(negedge clk); mem_resp_fire = 0;
    #1; chk("drain.redir_valid", {31'h0, redirect_valid}, 1);
    chk("drain.redir_pc", redirect_pc, EXV);
    redirect_ready = 1;
    @(negedge clk); redirect_ready = 0;
    #1; chk("drain.back_idle", {30'h0, redirect_valid, pipe_flush}, 32'h0);
    // ERET with a slow fetch handshake
    @(negedge clk); ws_valid = 1; ws_eret = 1; c0_epc = 32'hBFC00200;
    #1; chk("eret.flush_ex", {30'h0, eret_flush, wb_ex}, 32'h2);
    @(negedge clk); clear_inputs(); c0_epc = 32'h12345678;
    #1; chk("eret.one_cycle", {31'h0, eret_flush}, 0);
    for (int i = 0; i < 4; i++) begin
      chk("eret.hold_pc", redirect_valid ? redirect_pc : 32'hDEAD0000, 32'hBFC00200);
      @(negedge clk);
      #1;
    end
    chk("eret.hold_pc", redirect_valid ? redirect_pc : 32'hDEAD0000, 32'hBFC00200);
    redirect_ready = 1;
    @(negedge clk); redirect_ready = 0;
    #1; chk("eret.released", {31'h0, redirect_valid}, 0);
    // asynchronous reset while in REDIR
    @(negedge clk); ws_valid = 1; ws_ex_sys = 1;
    @(negedge clk); clear_inputs();
    #1; chk("rst.in_redir", {31'h0, redirect_valid}, 1);
    #1; resetn = 0;
    #1; chk("rst.async", {redirect_valid, pipe_flush, redirect_pc[29:0]}, 32'h0);
    @(negedge clk); resetn = 1;
    m_mode = 0; m_cnt = 0; m_tgt = 0;
    // random run against the model
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      ws_valid = $urandom_range(0, 1) == 1;
      ws_pc = $urandom; ws_data_addr = $urandom; c0_epc = $urandom;
      ws_bd = $urandom_range(0, 1) == 1;
      ws_ex_adel_if = $urandom_range(0, 11) == 0;
      ws_ex_ri = $urandom_range(0, 11) == 0;
      ws_ex_ov = $urandom_range(0, 11) == 0;
      ws_ex_sys = $urandom_range(0, 11) == 0;
      ws_ex_bp = $urandom_range(0, 11) == 0;
      ws_ex_adel_ld = $urandom_range(0, 11) == 0;
      ws_ex_ades = $urandom_range(0, 11) == 0;
      ws_eret = $urandom_range(0, 9) == 0;
      has_int = $urandom_range(0, 15) == 0;
      mem_req_fire = (m_mode == 0) && ($urandom_range(0, 2) == 0);
      mem_resp_fire = $urandom_range(0, 3) == 0;
      redirect_ready = $urandom_range(0, 1) == 1;
      assert (!(m_mode == 1 && mem_req_fire));
      #1;
      exp_v = model_out();
      n_cmp++;
      if (got !== exp_v) begin
        n_bad++;
        $display("FAIL random[%0d]: got %h expected %h", k, got, exp_v);
      end
      model_step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/wb_exc_ctrl.md
Name: wb_exc_ctrl

Overview:
- Writeback-stage exception/ERET controller: the producer side of the CP0 exception interface (wb_ex, wb_excode, wb_bd, wb_pc, wb_badvaddr, eret_flush).
- Prioritises per-instruction exception flags plus the CP0 interrupt request, issues a one-cycle commit pulse to CP0 and flushes the pipeline.
- Drains outstanding data-SRAM responses, then holds a redirect PC (exception vector or EPC) until fetch accepts it.

Parameters:
- EX_VECTOR, 32'hBFC00380, exception entry PC (Status.BEV fixed at 1).
- OUTS_W, 3, width of the outstanding data-request counter.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous reset, active low
- ws_valid  in  1  WB holds a valid instruction this cycle
- ws_pc  in  32  PC of WB instruction
- ws_bd  in  1  WB instruction is in a branch delay slot
- ws_ex_adel_if  in  1  fetch address error
- ws_ex_ri  in  1  reserved instruction
- ws_ex_ov  in  1  integer overflow
- ws_ex_sys  in  1  syscall
- ws_ex_bp  in  1  break
- ws_ex_adel_ld  in  1  load address error
- ws_ex_ades  in  1  store address error
- ws_data_addr  in  32  load/store effective address
- ws_eret  in  1  WB instruction is ERET
- has_int  in  1  CP0 interrupt pending
- c0_epc  in  32  CP0 EPC
- mem_req_fire  in  1  data request accepted by SRAM this cycle
- mem_resp_fire  in  1  data response returned this cycle
- redirect_ready  in  1  fetch accepts redirect
- wb_ex  out  1  exception commit pulse to CP0
- wb_excode  out  5  exception code
- wb_bd  out  1  BD bit for CP0
- wb_pc  out  32  faulting PC
- wb_badvaddr  out  32  bad virtual address
- eret_flush  out  1  ERET commit pulse to CP0
- pipe_flush  out  1  kill all stages older than WB (level)
- resp_discard  out  1  current mem response is stale and must be dropped
- redirect_valid  out  1  redirect PC is valid
- redirect_pc  out  32  target PC

Behaviour:
- States: IDLE, DRAIN, REDIR. Reset (resetn low, async) -> IDLE, counter 0, every output 0.
- Outstanding counter: +1 on mem_req_fire, -1 on mem_resp_fire, unchanged when both fire; saturates at all-ones and at 0. It runs in every state.
- Trigger (IDLE only): ws_valid & (has_int | any ws_ex_* | ws_eret).
- Excode priority, highest first:
  - has_int: 0x00
  - adel_if: 0x04
  - ri: 0x0a
  - ov: 0x0c
  - sys: 0x08
  - bp: 0x09
  - adel_ld: 0x04
  - ades: 0x05
- An exception or interrupt beats ERET in the same cycle; ERET then produces no eret_flush.
- Exception trigger cycle (combinational from inputs):
  - wb_ex=1; wb_excode per priority; wb_bd=ws_bd; wb_pc=ws_pc.
  - wb_badvaddr = ws_pc for adel_if, ws_data_addr for adel_ld/ades, otherwise 0.
  - Target latched = EX_VECTOR.
- ERET trigger cycle: eret_flush=1; target latched = c0_epc as sampled that cycle.
- wb_ex and eret_flush are exactly one cycle wide and are never asserted outside the trigger cycle.
- Next state after trigger: DRAIN if the counter after this cycle's update is nonzero, else REDIR.
- pipe_flush = 1 in the trigger cycle and throughout DRAIN and REDIR.
- DRAIN:
  - resp_discard = mem_resp_fire.
  - New mem_req_fire is illegal (pipeline is flushed); the bench asserts it stays 0.
  - Exit to REDIR in the cycle after the counter reaches 0.
- REDIR:
  - redirect_valid=1 and redirect_pc=target, both stable until redirect_ready.
  - On redirect_valid & redirect_ready -> IDLE; redirect_valid drops next cycle.
- has_int and ws_* are ignored outside IDLE; no second trigger until back in IDLE.
- Asynchronous reset mid-DRAIN/REDIR returns to IDLE immediately with all outputs 0.

Test Plan:
- ws_valid=1, ws_ex_ov=1, ws_pc=0xBFC00100, ws_bd=1, counter 0 -> one-cycle wb_ex, excode 0x0c, wb_bd=1, wb_pc=0xBFC00100; next cycle redirect_valid=1, redirect_pc=0xBFC00380.
- ws_ex_ri=1 and ws_ex_sys=1 together -> excode 0x0a. has_int=1 with ws_ex_adel_if=1 -> excode 0x00, wb_badvaddr=0.
- ws_ex_ades=1, ws_data_addr=0x80000003 -> excode 0x05, wb_badvaddr=0x80000003.
- Two mem_req_fire, then an exception -> state DRAIN. Two mem_resp_fire 3 cycles apart -> resp_discard pulses twice; redirect_valid only after the second.
- ws_eret=1, c0_epc=0xBFC00200, redirect_ready held low 4 cycles -> eret_flush one cycle, wb_ex=0, redirect_pc stable at 0xBFC00200 until handshake.
- ws_eret=1 with has_int=1 -> wb_ex=1 excode 0x00, eret_flush=0. resetn pulled low in REDIR -> redirect_valid=0 and pipe_flush=0 immediately.
